// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous square wave in i_clock cycles.
// Optional high-time measurement via `define CLOCK_PERIOD_METER_DUTY_EN.
module clock_period_meter #(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_sample,
  output logic [WIDTH-1:0] o_period,
  output logic             o_valid,
  output logic             o_edge,
  output logic             o_stalled
`ifdef CLOCK_PERIOD_METER_DUTY_EN
  ,
  output logic [WIDTH-1:0] o_high_time
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;
  logic                   w_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       w_cnt_nxt;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       w_period_nxt;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic                   r_edge;
  logic                   r_stalled;
  logic                   w_stalled_nxt;

  // Synchroniser chain; SYNC_STAGES must be at least 2
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sample};
      r_prev <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;

  // State and output registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_edge    <= 1'b0;
      r_stalled <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_valid   <= w_valid_nxt;
      r_edge    <= w_rise;
      r_stalled <= w_stalled_nxt;
    end
  end

  // A rise in MEASURE wins over the stall check, so a period of CNT_MAX is still reported
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_stalled_nxt = r_stalled;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_period_nxt = r_cnt;
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = CNT_ONE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt   = STALLED;
          w_stalled_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      STALLED: begin
        if (w_rise) begin
          w_state_nxt   = MEASURE;
          w_cnt_nxt     = CNT_ONE;
          w_stalled_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_cnt_nxt     = '0;
        w_stalled_nxt = 1'b0;
      end
    endcase
  end

  assign o_period  = r_period;
  assign o_valid   = r_valid;
  assign o_edge    = r_edge;
  assign o_stalled = r_stalled;

`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [WIDTH-1:0] r_high_cnt;
  logic [WIDTH-1:0] r_high_hold;
  logic [WIDTH-1:0] r_high_time;
  logic             w_fall;

  assign w_fall = ~w_s & r_prev;

  // High-phase counter, captured on the fall and published alongside o_valid
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_high_cnt  <= '0;
      r_high_hold <= '0;
      r_high_time <= '0;
    end else begin
      if (w_rise) begin
        r_high_cnt <= CNT_ONE;
      end else if (w_s && (r_high_cnt != CNT_MAX)) begin
        r_high_cnt <= r_high_cnt + CNT_ONE;
      end
      if (w_fall) begin
        r_high_hold <= r_high_cnt;
      end
      if (w_valid_nxt) begin
        r_high_time <= r_high_hold;
      end
    end
  end

  assign o_high_time = r_high_time;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomised bench for clock_period_meter against a timestamp-based reference model.
module tb_clock_period_meter;

  localparam int unsigned WIDTH = 6;
  localparam int          MAXC  = 63;
  localparam int          HMAX  = 16384;

  logic             i_clock   = 1'b0;
  logic             i_reset_n = 1'b0;
  logic             i_sample  = 1'b0;
  logic [WIDTH-1:0] o_period;
  logic             o_valid;
  logic             o_edge;
  logic             o_stalled;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [WIDTH-1:0] o_high_time;
`endif

  clock_period_meter #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2)
  ) u_dut (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_sample   (i_sample),
    .o_period   (o_period),
    .o_valid    (o_valid),
    .o_edge     (o_edge),
    .o_stalled  (o_stalled)
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    ,
    .o_high_time(o_high_time)
`endif
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;

  // Model: input history by cycle, plus timestamp of the last detected rise
  bit hist [HMAX];
  int n;
  int last;
  bit have_last;
  int exp_period;
  int run;
  int last_high;
  int exp_high;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t cycle %0d: got %0d expected %0d", tag, $time, n, got, exp);
    end
  endtask

  function automatic bit h(input int k);
    if (k < 0 || k >= HMAX) return 1'b0;
    return hist[k];
  endfunction

  task automatic model_reset();
    n = 0;
    foreach (hist[i]) hist[i] = 1'b0;
    hist[0]    = i_sample;
    have_last  = 1'b0;
    last       = 0;
    exp_period = 0;
    run        = 0;
    last_high  = 0;
    exp_high   = 0;
  endtask

  // One clock: check outputs against the model, then drive the next input value
  task automatic step(input bit v);
    bit cur, prv, e, vexp, sexp;
    @(posedge i_clock);
    n++;
    @(negedge i_clock);
    cur = h(n - 3);
    prv = h(n - 4);
    if (cur && !prv) run = 1;
    else if (cur && prv && run < MAXC) run++;
    else if (!cur && prv) last_high = run;
    e    = cur && !prv;
    vexp = e && have_last && ((n - last) <= MAXC);
    if (vexp) begin
      exp_period = n - last;
      exp_high   = last_high;
    end
    if (e) begin
      have_last = 1'b1;
      last      = n;
    end
    sexp = have_last && !e && ((n - last) >= MAXC);
    check_eq("edge", 32'(o_edge), 32'(e));
    check_eq("valid", 32'(o_valid), 32'(vexp));
    check_eq("stalled", 32'(o_stalled), 32'(sexp));
    check_eq("period", 32'(o_period), exp_period);
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    check_eq("high_time", 32'(o_high_time), exp_high);
`endif
    i_sample = v;
    if (n < HMAX) hist[n] = v;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_period"}, 32'(o_period), 0);
    check_eq({tag, "_valid"}, 32'(o_valid), 0);
    check_eq({tag, "_edge"}, 32'(o_edge), 0);
    check_eq({tag, "_stalled"}, 32'(o_stalled), 0);
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    check_eq({tag, "_high_time"}, 32'(o_high_time), 0);
`endif
  endtask

  initial begin
    n = 0;
    repeat (3) @(negedge i_clock);
    check_all_zero("reset");
    i_reset_n = 1'b1;
    model_reset();

    repeat (4) step(1'b0);
    wave(8, 8, 6);                       // P = 16
    repeat (5) step(1'b1);               // lone rise, then stall
    repeat (90) step(1'b0);
    wave(8, 8, 3);                       // recovery: no valid, then valid
    wave(8, 8, 4);                       // 16 -> 10 transition
    wave(5, 5, 6);
    wave(30, 33, 3);                     // P = 63: reported, no stall
    wave(32, 32, 3);                     // P = 64: stalls every period
    wave(8, 8, 3);
    wave(4, 12, 5);                      // 4 high of 16

    for (int i = 0; i < 40; i++) begin
      int hi, lo;
      hi = int'($urandom_range(2, 36));
      lo = int'($urandom_range(2, 36));
      wave(hi, lo, int'($urandom_range(1, 3)));
    end

    // Asynchronous reset with cnt = 7 in MEASURE
    repeat (6) step(1'b0);
    repeat (10) step(1'b1);
    #2 i_reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge i_clock);
    i_reset_n = 1'b1;
    model_reset();
    repeat (3) step(1'b1);
    repeat (8) step(1'b0);
    wave(8, 8, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
